// File: rtl/jalr_redirect_ctrl_pkg.sv
// otter_pkg: shared forwarding-select and JALR control state types.
package otter_pkg;
  typedef enum logic [1:0] {
    FWD_RF = 2'b00,
    FWD_MW = 2'b01,
    FWD_EM = 2'b10,
    FWD_IE = 2'b11
  } fwd_sel_t;
  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    REDIRECT
  } jalr_state_t;
endpackage

// File: rtl/jalr_redirect_ctrl_target_gen.sv
// jalr_target_gen: forwarded-operand mux plus (operand + imm) & ~1 target adder.
module jalr_target_gen
  import otter_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  fwd_sel_t          sel,
  input  logic [XLEN-1:0]   rfVal,
  input  logic [XLEN-1:0]   mwVal,
  input  logic [XLEN-1:0]   emVal,
  input  logic [XLEN-1:0]   ieVal,
  input  logic [XLEN-1:0]   imm,
  output logic [XLEN-1:0]   target,
  output logic              misaligned
);
  logic [XLEN-1:0] opnd, sum;
  always_comb begin
    opnd = sel == FWD_MW ? mwVal : sel == FWD_EM ? emVal : sel == FWD_IE ? ieVal : rfVal;
  end
  assign sum        = opnd + imm;
  assign target     = sum & ~XLEN'(1);
  assign misaligned = sum[1];
endmodule

// File: rtl/jalr_redirect_ctrl.sv
// jalr_redirect_ctrl: stalls a decode-stage JALR on load-use, then issues a one-cycle PC redirect.
// Optional stall watchdog enabled by JALR_STALL_TIMEOUT_EN.
module jalr_redirect_ctrl
  import otter_pkg::*;
#(
  parameter int XLEN          = 32,
  parameter int STALL_TIMEOUT = 4
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            jalr_valid,
  input  logic [1:0]      rs_select,
  input  logic            stall_req,
  input  logic [XLEN-1:0] rf_rs1,
  input  logic [XLEN-1:0] mw_fwd,
  input  logic [XLEN-1:0] em_fwd,
  input  logic [XLEN-1:0] ie_fwd,
  input  logic [XLEN-1:0] imm_i,
  output logic            stall_pc,
  output logic            bubble_ex,
  output logic            redirect_valid,
  output logic [XLEN-1:0] redirect_pc,
  output logic            flush_if,
  output logic            target_misaligned,
  output logic            stall_err
);
  jalr_state_t     state;
  logic [XLEN-1:0] target;
  logic            misal, resolve, timeout, stall;

  jalr_target_gen #(.XLEN(XLEN)) targetGen (
    .sel       (fwd_sel_t'(rs_select)),
    .rfVal     (rf_rs1),
    .mwVal     (mw_fwd),
    .emVal     (em_fwd),
    .ieVal     (ie_fwd),
    .imm       (imm_i),
    .target    (target),
    .misaligned(misal)
  );

`ifdef JALR_STALL_TIMEOUT_EN
  localparam int CW = $clog2(STALL_TIMEOUT + 1);
  logic [CW-1:0] waitCnt;
  assign timeout = state == WAIT && stall_req && waitCnt == CW'(STALL_TIMEOUT);
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      waitCnt   <= '0;
      stall_err <= 1'b0;
    end else begin
      waitCnt   <= (state == WAIT && jalr_valid && stall_req && !timeout) ? waitCnt + 1'b1 : '0;
      stall_err <= stall_err | (timeout & jalr_valid);
    end
  end
`else
  assign timeout   = 1'b0;
  assign stall_err = 1'b0;
`endif

  // A forced resolve on timeout uses whatever rs_select is presented that cycle.
  assign resolve = jalr_valid && ((state == IDLE && !stall_req) || (state == WAIT && (!stall_req || timeout)));
  assign stall   = !RST && jalr_valid && stall_req && !resolve && state != REDIRECT;
  assign stall_pc       = stall;
  assign bubble_ex      = stall;
  assign redirect_valid = state == REDIRECT;
  assign flush_if       = state == REDIRECT;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state             <= IDLE;
      redirect_pc       <= '0;
      target_misaligned <= 1'b0;
    end else begin
      state <= state == REDIRECT ? IDLE : resolve ? REDIRECT : (jalr_valid && stall_req) ? WAIT : IDLE;
      if (resolve) begin
        redirect_pc       <= target;
        target_misaligned <= misal;
      end
    end
  end
endmodule
